// File: rtl/serial_borrow_subtractor.sv
// Bit-serial A - B - Bin, LSB first through one borrow flop; WIDTH cycles from accept to out_valid.
// Holds result and out_valid while out_ready is low; in_ready is high only when idle.
module serial_borrow_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             br;
   logic             a_msb, b_msb;
   logic [CW-1:0]    cnt;

   logic             a_bit, b_bit, d_bit, br_nxt, last;
   logic [WIDTH-1:0] res_nxt;

   // One full-subtractor slice operating on the current LSBs.
   always_comb begin
      a_bit   = a_sr[0];
      b_bit   = b_sr[0];
      d_bit   = a_bit ^ b_bit ^ br;
      br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
      res_nxt = {d_bit, res_sr[WIDTH-1:1]};
      last    = (cnt == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= bin;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               res_sr <= res_nxt;
               br     <= br_nxt;
               cnt    <= cnt + CW'(1);
               // Signed overflow: operand signs differ and result sign departs from the minuend.
               if (last) begin
                  diff <= res_nxt;
                  bout <= br_nxt;
                  ovf  <= (a_msb != b_msb) & (res_nxt[WIDTH-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed and randomized checks of serial_borrow_subtractor at WIDTH=8.
module tb_serial_borrow_subtractor;

   logic       clk, rst, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
   logic [7:0] a, b, diff;

   int n_cmp = 0;
   int n_err = 0;

   serial_borrow_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
      chk("send_rdy", in_ready, 1);
      in_valid = 1'b1; a = va; b = vb; bin = vbin;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int k);
      k = 0;
      while (!out_valid && k < 20) begin
         chk("busy_rdy", in_ready, 0);
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_vld", out_valid, 0);
      chk("post_rdy", in_ready, 1);
   endtask

   task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vbin, input logic [7:0] ed, input logic eb, input logic eo);
      int k;
      send(va, vb, vbin);
      wait_out(k);
      chk({tag, "_lat"}, k, 8);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_bout"}, bout, eb);
      chk({tag, "_ovf"}, ovf, eo);
      take();
   endtask

   logic [9:0] exp_q[$];

   initial begin
      int k, seen, sent, got, cyc;
      logic [8:0] r;
      logic [7:0] ra, rb;
      logic       rbin;
      logic [9:0] e;

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      do_op("5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      do_op("3m5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
      do_op("0m0b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op("80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      do_op("7Fm_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // Backpressure: 0x10 - 0x20 = 0xF0 with borrow, no signed overflow.
      send(8'h10, 8'h20, 1'b0);
      wait_out(k);
      chk("bp_lat", k, 8);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0]; a = 8'($urandom); b = 8'($urandom); bin = i[1];
         @(posedge clk); #1;
         chk("bp_vld", out_valid, 1);
         chk("bp_diff", diff, 8'hF0);
         chk("bp_bout", bout, 1);
         chk("bp_ovf", ovf, 0);
         chk("bp_rdy", in_ready, 0);
      end
      in_valid = 1'b0;
      take();
      chk("bp_diff_hold", diff, 8'hF0);

      // Reset abort three cycles into RUN.
      send(8'h12, 8'h34, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bout", bout, 0);
      chk("abort_ovf", ovf, 0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort_no_vld", seen, 0);
      do_op("AAm55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

      // Randomized stream with random in_valid/out_ready gaps.
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 60000) begin
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a = ra; b = rb; bin = rbin;
         if (in_valid && in_ready) begin
            r = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            e = {(ra[7] != rb[7]) && (r[7] != ra[7]), r};
            exp_q.push_back(e);
            sent++;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("rand_extra", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rand_res", {ovf, bout, diff}, e);
            end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rand_count", got, 1000);
      chk("rand_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial subtractor that computes `A - B - Bin` one bit per clock, LSB first, through a single stored borrow flop. It is the inverse-operation companion to the team's parallel ripple-carry adder and is intended for area-constrained datapaths where WIDTH-cycle latency is acceptable. Operands enter and results leave through ready/valid handshakes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are 2 to 64.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands `a`, `b`, `bin` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result is valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow-out; 1 iff `a < b + bin` (unsigned).
- `ovf`  out  1  two's-complement overflow of the signed subtraction.

## Operation
- FSM states: IDLE, RUN, DONE.
- Decided: one clock; reset is asynchronous and active-high.
- Reset value of state: IDLE.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`=1: capture `a` and `b` into shift registers, load the borrow flop with `bin`, latch `a[WIDTH-1]` and `b[WIDTH-1]`, clear the bit counter, and go to RUN.
- RUN (one bit per edge, bit i = LSB of each shift register):
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d_i` shifts into the result register from the MSB end. The operand registers shift right.
  - The counter increments. At the edge where the counter equals WIDTH-1 (the WIDTH-th RUN edge), go to DONE.
  - On that edge, load `diff` with the completed result, `bout` with the final `br'`, and `ovf = (a_msb != b_msb) & (diff_msb != a_msb)`.
- DONE:
  - `out_valid`=1.
  - `diff`, `bout`, `ovf` hold stable.
  - On an edge with `out_ready`=1, go to IDLE.
- `diff`, `bout`, `ovf` retain their last values in IDLE and RUN. They update only on entry to DONE.
- Input ports are sampled only at the accept edge. Changes to `a`, `b`, `bin` during RUN or DONE have no effect.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Reset mid-operation: `rst` asserted in any state immediately forces IDLE and the reset output values. The partial result is discarded, and no `out_valid` pulse is produced for the aborted operation.

## Timing
- `in_ready` and `out_valid` are decoded combinationally from the registered state. There is no combinational path from any input to any output.
- Accept edge T0: `in_valid & in_ready` sampled high. RUN occupies edges T1..T_WIDTH. `out_valid` is high from just after T_WIDTH. Latency from accept to `out_valid` is WIDTH cycles.
- Output handshake edge: `out_valid & out_ready`. IDLE is entered after it, and `in_ready` rises in the following cycle. There is no same-cycle result/operand turnaround.
- Minimum issue interval is WIDTH+2 cycles, with `out_ready` tied high.
- Backpressure: `out_valid` and the results hold indefinitely while `out_ready`=0.

## Test plan
All scenarios use WIDTH=8.

- 0x05 - 0x03, `bin`=0 -> `diff`=0x02, `bout`=0, `ovf`=0. `out_valid` rises exactly 8 cycles after the accept edge. `in_ready` is low from T1 until after the output handshake.
- 0x03 - 0x05, `bin`=0 -> `diff`=0xFE, `bout`=1, `ovf`=0. Also 0x00 - 0x00 with `bin`=1 -> `diff`=0xFF, `bout`=1, `ovf`=0.
- Signed overflow cases:
  - 0x80 - 0x01 -> `diff`=0x7F, `bout`=0, `ovf`=1.
  - 0x7F - 0xFF -> `diff`=0x80, `bout`=1, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and `a`/`b`. `out_valid`, `diff`, `bout`, `ovf` stay constant and `in_ready` stays 0. Raise `out_ready`: one transfer occurs, then `in_ready`=1 the next cycle.
- Reset abort: assert `rst` 3 cycles into RUN. Outputs go to their reset values asynchronously, and no `out_valid` appears. After release, 0xAA - 0x55 -> `diff`=0x55, `bout`=0, `ovf`=1.
- Randomized back-to-back: 1000 random `a`/`b`/`bin` with random `in_valid`/`out_ready` gaps. Every result matches the `{bout, diff}` of a (WIDTH+1)-bit reference subtraction and the signed `ovf` rule, in order, with no drops or duplicates.
